calc_ctrl: RTL and testbench

Top-level sequencer for the DE10-Lite calculator. It debounces the two push-buttons and accepts decimal operand entry from the switches. It walks the user through operand A, operator, and operand B, launches the external arithmetic unit over a start/done handshake, and latches the result. It drives the `stage`/`data`/`result` inputs of the binary-to-BCD display converter. It does not consume `key1` in the result stage, where the display converter uses it for paging.

---
 rtl/calc_ctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_calc_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_ctrl.sv
// Calculator sequencer: debounces two keys, collects decimal operands and an operator,
// launches the external arithmetic unit and latches its result for the BCD display path.
//
// state    | meaning
// ENTER_A  | building operand A from switch digits
// SEL_OP   | choosing the operator code
// ENTER_B  | building operand B from switch digits
// LAUNCH   | one-cycle alu_start pulse, timeout counter cleared
// WAIT     | waiting for alu_done or timeout expiry
// SHOW     | result displayed; key1 left to the display converter for paging
module calc_ctrl #(
    parameter int DEB_CYCLES = 250000,
    parameter int TIMEOUT    = 1024
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        key0,
    input  logic        key1,
    input  logic [9:0]  sw,
    input  logic        alu_done,
    input  logic        alu_err,
    input  logic [39:0] alu_result,
    output logic        alu_start,
    output logic [1:0]  alu_op,
    output logic [19:0] op_a,
    output logic [19:0] op_b,
    output logic [1:0]  stage,
    output logic [19:0] data,
    output logic [39:0] result,
    output logic        busy,
    output logic        err
);

    localparam logic [2:0] S_ENTER_A = 3'd0;
    localparam logic [2:0] S_SEL_OP  = 3'd1;
    localparam logic [2:0] S_ENTER_B = 3'd2;
    localparam logic [2:0] S_LAUNCH  = 3'd3;
    localparam logic [2:0] S_WAIT    = 3'd4;
    localparam logic [2:0] S_SHOW    = 3'd5;

    localparam int              DCW     = $clog2(DEB_CYCLES + 1);
    localparam logic [DCW-1:0]  DEB_MAX = DCW'(DEB_CYCLES);
    localparam int              TCW     = $clog2(TIMEOUT + 1);
    localparam logic [TCW-1:0]  TMO_MAX = TCW'(TIMEOUT);
    localparam logic [23:0]     OPND_MAX = 24'd999999;

    // ------------------------------------------------------------------
    // Key conditioning: index 0 = key0 (enter), index 1 = key1 (next)
    // ------------------------------------------------------------------
    logic [1:0]     key_raw;
    logic [1:0]     sync1_q;
    logic [1:0]     sync2_q;
    logic [1:0]     level_q;
    logic [1:0]     press_q;
    logic [DCW-1:0] deb_cnt_q [2];
    logic           p0;
    logic           p1;

    assign key_raw = {key1, key0};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            level_q <= 2'b11;
            press_q <= 2'b00;
            for (int k = 0; k < 2; k++) begin
                deb_cnt_q[k] <= '0;
            end
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
            press_q <= 2'b00;
            for (int k = 0; k < 2; k++) begin
                // Any return to the accepted level restarts the stability window.
                if (sync2_q[k] == level_q[k]) begin
                    deb_cnt_q[k] <= '0;
                end else if (deb_cnt_q[k] == DEB_MAX) begin
                    level_q[k]   <= sync2_q[k];
                    deb_cnt_q[k] <= '0;
                    press_q[k]   <= ~sync2_q[k];
                end else begin
                    deb_cnt_q[k] <= deb_cnt_q[k] + 1'b1;
                end
            end
        end
    end

    assign p0 = press_q[0];
    assign p1 = press_q[1];

    // ------------------------------------------------------------------
    // Operand digit entry (shared by A and B)
    // ------------------------------------------------------------------
    logic [2:0]     state_q,  state_d;
    logic [19:0]    op_a_q,   op_a_d;
    logic [19:0]    op_b_q,   op_b_d;
    logic [1:0]     alu_op_q, alu_op_d;
    logic [39:0]    result_q, result_d;
    logic           err_q,    err_d;
    logic           busy_q,   busy_d;
    logic [TCW-1:0] tmo_q,    tmo_d;
    logic [TCW-1:0] tmo_inc;

    logic [19:0]    cur_opnd;
    logic [23:0]    cur_ext;
    logic [23:0]    times10;
    logic [23:0]    cand;
    logic           digit_ok;
    logic [19:0]    entry_next;

    assign cur_opnd = (state_q == S_ENTER_B) ? op_b_q : op_a_q;
    assign cur_ext  = {4'b0000, cur_opnd};
    assign times10  = (cur_ext << 3) + (cur_ext << 1);
    assign cand     = times10 + {20'd0, sw[3:0]};
    assign digit_ok = (sw[3:0] <= 4'd9) && (cand <= OPND_MAX);

    always_comb begin
        entry_next = cur_opnd;
        if (sw[9]) begin
            entry_next = '0;
        end else if (digit_ok) begin
            entry_next = cand[19:0];
        end
    end

    assign tmo_inc = tmo_q + 1'b1;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        alu_op_d = alu_op_q;
        result_d = result_q;
        err_d    = err_q;
        tmo_d    = tmo_q;

        case (state_q)
            S_ENTER_A: begin
                if (p1) begin
                    state_d = S_SEL_OP;
                end else if (p0) begin
                    op_a_d = entry_next;
                end
            end
            S_SEL_OP: begin
                if (p1) begin
                    state_d = S_ENTER_B;
                end else if (p0) begin
                    alu_op_d = sw[1:0];
                end
            end
            S_ENTER_B: begin
                if (p1) begin
                    state_d = S_LAUNCH;
                end else if (p0) begin
                    op_b_d = entry_next;
                end
            end
            S_LAUNCH: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done arriving in the expiry cycle takes priority over the timeout.
                if (alu_done) begin
                    result_d = alu_err ? 40'd0 : alu_result;
                    err_d    = alu_err;
                    state_d  = S_SHOW;
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == TMO_MAX) begin
                        result_d = '0;
                        err_d    = 1'b1;
                        state_d  = S_SHOW;
                    end
                end
            end
            S_SHOW: begin
                if (p0) begin
                    state_d  = S_ENTER_A;
                    op_a_d   = '0;
                    op_b_d   = '0;
                    alu_op_d = 2'b00;
                    result_d = '0;
                    err_d    = 1'b0;
                end
            end
            default: begin
                state_d = S_ENTER_A;
            end
        endcase

        busy_d = (state_d == S_LAUNCH) || (state_d == S_WAIT);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_ENTER_A;
            op_a_q   <= '0;
            op_b_q   <= '0;
            alu_op_q <= 2'b00;
            result_q <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            alu_op_q <= alu_op_d;
            result_q <= result_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            tmo_q    <= tmo_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        stage = 2'd2;
        data  = op_b_q;
        case (state_q)
            S_ENTER_A: begin
                stage = 2'd0;
                data  = op_a_q;
            end
            S_SEL_OP: begin
                stage = 2'd1;
                data  = {18'd0, alu_op_q};
            end
            S_SHOW: begin
                stage = 2'd3;
            end
            default: begin
                stage = 2'd2;
            end
        endcase
    end

    assign alu_start = (state_q == S_LAUNCH);
    assign alu_op    = alu_op_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign result    = result_q;
    assign busy      = busy_q;
    assign err       = err_q;

    logic unused_sw;
    assign unused_sw = ^sw[8:4];

endmodule

// File: tb/tb_calc_ctrl.sv
// Scoreboard bench for calc_ctrl: expected SHOW contents are queued at launch and
// compared by an independent monitor when the display enters the result stage.
module tb_calc_ctrl;

    localparam int DEB = 4;
    localparam int TMO = 16;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        key0 = 1'b1;
    logic        key1 = 1'b1;
    logic [9:0]  sw = '0;
    logic        model_done = 1'b0;
    logic        stray_done = 1'b0;
    logic        alu_done;
    logic        alu_err_r = 1'b0;
    logic [39:0] alu_res_r = 40'hAB_CDEF_0123;

    logic        alu_start;
    logic [1:0]  alu_op;
    logic [19:0] op_a;
    logic [19:0] op_b;
    logic [1:0]  stage;
    logic [19:0] data;
    logic [39:0] result;
    logic        busy;
    logic        err;

    assign alu_done = model_done | stray_done;

    calc_ctrl #(.DEB_CYCLES(DEB), .TIMEOUT(TMO)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .key0       (key0),
        .key1       (key1),
        .sw         (sw),
        .alu_done   (alu_done),
        .alu_err    (alu_err_r),
        .alu_result (alu_res_r),
        .alu_start  (alu_start),
        .alu_op     (alu_op),
        .op_a       (op_a),
        .op_b       (op_b),
        .stage      (stage),
        .data       (data),
        .result     (result),
        .busy       (busy),
        .err        (err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [39:0] res;
        logic        e;
        logic [19:0] a;
        logic [19:0] b;
        logic [1:0]  op;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    // Arithmetic unit model
    int          model_mode = 0;
    int          model_delay = 0;
    logic [39:0] model_res = '0;
    logic        model_err = 1'b0;
    int          start_count = 0;
    int          last_start_cyc = 0;

    initial begin
        forever begin
            @(negedge CLK);
            if (alu_start === 1'b1) begin
                start_count++;
                last_start_cyc = cyc;
                if (model_mode == 1) begin
                    repeat (model_delay) @(negedge CLK);
                    alu_res_r  = model_res;
                    alu_err_r  = model_err;
                    model_done = 1'b1;
                    @(negedge CLK);
                    model_done = 1'b0;
                    alu_err_r  = 1'b0;
                    alu_res_r  = 40'hAB_CDEF_0123;
                end
            end
        end
    end

    // Monitor
    logic [1:0] prev_stage = 2'd0;
    exp_t       mon_e;

    initial begin
        forever begin
            @(negedge CLK);
            if (stage == 2'd3 && prev_stage != 2'd3) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_show got=1 want=0");
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("show_result", result, mon_e.res);
                    chk("show_err", err, mon_e.e);
                    chk("show_op_a", op_a, mon_e.a);
                    chk("show_op_b", op_b, mon_e.b);
                    chk("show_alu_op", alu_op, mon_e.op);
                    chk("show_busy", busy, 0);
                    chk("show_latency", cyc - last_start_cyc, mon_e.lat);
                end
            end
            prev_stage = stage;
        end
    end

    task automatic press(input bit k0, input bit k1);
        if (k0) key0 = 1'b0;
        if (k1) key1 = 1'b0;
        repeat (DEB + 5) @(negedge CLK);
        key0 = 1'b1;
        key1 = 1'b1;
        repeat (DEB + 5) @(negedge CLK);
    endtask

    task automatic digit(input int d);
        sw = 10'(d);
        press(1, 0);
    endtask

    task automatic wait_show();
        int n = 0;
        while (stage != 2'd3 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk("show_reached", stage == 2'd3, 1);
    endtask

    initial begin
        int sc;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        chk("rst_stage", stage, 0);
        chk("rst_data", data, 0);
        chk("rst_result", result, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", alu_start, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_op_a", op_a, 0);
        chk("rst_op_b", op_b, 0);

        // Entry and add
        digit(1); digit(2); digit(3);
        chk("add_op_a", op_a, 123);
        chk("add_data_a", data, 123);
        press(0, 1);
        chk("add_stage_op", stage, 1);
        sw = 10'd0;
        press(1, 0);
        chk("add_data_op", data, 0);
        press(0, 1);
        chk("add_stage_b", stage, 2);
        digit(4); digit(5);
        chk("add_op_b", op_b, 45);
        chk("add_data_b", data, 45);
        model_mode = 1; model_delay = 5; model_res = 40'd168; model_err = 1'b0;
        sb_q.push_back(exp_t'{40'd168, 1'b0, 20'd123, 20'd45, 2'd0, 6});
        sc = start_count;
        press(0, 1);
        wait_show();
        chk("add_start_pulses", start_count - sc, 1);
        press(0, 1);
        chk("show_key1_ignored", stage, 3);
        chk("show_key1_result", result, 168);
        sw = 10'd0;
        press(1, 0);
        chk("clr_stage", stage, 0);
        chk("clr_op_a", op_a, 0);
        chk("clr_op_b", op_b, 0);
        chk("clr_result", result, 0);
        chk("clr_err", err, 0);

        // Saturation and invalid digit
        repeat (6) digit(9);
        chk("sat_999999", op_a, 999999);
        digit(5);
        chk("sat_overflow", op_a, 999999);
        digit(12);
        chk("sat_bad_digit", op_a, 999999);
        sw = 10'h200;
        press(1, 0);
        chk("sat_clear", op_a, 0);

        // Simultaneous keys and bounce
        digit(7);
        chk("sim_op_a_pre", op_a, 7);
        sw = 10'd3;
        press(1, 1);
        chk("sim_stage", stage, 1);
        chk("sim_op_a", op_a, 7);
        chk("sim_alu_op", alu_op, 0);
        key0 = 1'b0;
        repeat (2) @(negedge CLK);
        key0 = 1'b1;
        repeat (DEB + 8) @(negedge CLK);
        chk("glitch_alu_op", alu_op, 0);
        chk("glitch_stage", stage, 1);

        // Timeout with sub operator
        sw = 10'd1;
        press(1, 0);
        chk("to_alu_op", alu_op, 1);
        press(0, 1);
        model_mode = 0;
        sb_q.push_back(exp_t'{40'd0, 1'b1, 20'd7, 20'd0, 2'd1, TMO + 1});
        press(0, 1);
        chk("to_busy_wait", busy, 1);
        chk("to_stage_wait", stage, 2);
        wait_show();
        chk("to_busy_fell", busy, 0);
        sw = 10'd0;
        press(1, 0);

        // Error reported by the arithmetic unit
        digit(5);
        press(0, 1);
        sw = 10'd3;
        press(1, 0);
        press(0, 1);
        model_mode = 1; model_delay = 3; model_res = 40'h12345; model_err = 1'b1;
        sb_q.push_back(exp_t'{40'd0, 1'b1, 20'd5, 20'd0, 2'd3, 4});
        press(0, 1);
        wait_show();
        sw = 10'd0;
        press(1, 0);

        // Done in the exact expiry cycle; operator defaults to add after SHOW
        digit(2);
        press(0, 1);
        press(0, 1);
        model_mode = 1; model_delay = TMO; model_res = 40'd7; model_err = 1'b0;
        sb_q.push_back(exp_t'{40'd7, 1'b0, 20'd2, 20'd0, 2'd0, TMO + 1});
        press(0, 1);
        wait_show();
        sw = 10'd0;
        press(1, 0);

        // Reset mid-WAIT, then a stray done
        digit(9);
        press(0, 1);
        press(0, 1);
        model_mode = 0;
        press(0, 1);
        chk("rw_busy_pre", busy, 1);
        RST = 1'b1;
        #1;
        chk("rw_start", alu_start, 0);
        chk("rw_busy", busy, 0);
        chk("rw_stage", stage, 0);
        chk("rw_op_a", op_a, 0);
        chk("rw_data", data, 0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        alu_res_r  = 40'd55;
        alu_err_r  = 1'b1;
        stray_done = 1'b1;
        @(negedge CLK);
        stray_done = 1'b0;
        alu_err_r  = 1'b0;
        repeat (3) @(negedge CLK);
        chk("stray_stage", stage, 0);
        chk("stray_result", result, 0);
        chk("stray_err", err, 0);
        chk("stray_busy", busy, 0);

        chk("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
